// File: rtl/dictionary_session_arbiter_pkg.sv
// Shared types and helpers for the dictionary session arbiter.
// Holds the element types, FSM states and the round-robin pick function.
package dictionary_session_arbiter_pkg;

    typedef logic [15:0] id_t;
    typedef logic [3:0]  type_t;

    localparam int ID_W        = $bits(id_t);
    localparam int TYPE_W      = $bits(type_t);
    localparam int MAX_CLIENTS = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        IDS,
        RELEASE
    } arb_state_t;

    // First requester at or after ptr, modulo n, as a one-hot vector
    function automatic logic [MAX_CLIENTS-1:0] rr_pick(
        input logic [MAX_CLIENTS-1:0] req,
        input logic [3:0]             ptr,
        input int                     n
    );
        logic [MAX_CLIENTS-1:0] g;
        logic                   found;
        int                     idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_CLIENTS; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !found && req[idx[3:0]]) begin
                g[idx[3:0]] = 1'b1;
                found       = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/dictionary_session_arbiter_rr_arbiter.sv
// Round-robin picker with a registered priority pointer.
// The pointer moves past the current owner when adv pulses.
module rr_arbiter
    import dictionary_session_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         adv,
    input  logic [N-1:0] gnt,
    output logic [N-1:0] pick
);

    localparam int PW = $clog2(N);

    logic [PW-1:0]          ptr;
    logic [PW-1:0]          gidx;
    logic [MAX_CLIENTS-1:0] pick_w;
    logic                   unused_hi;

    assign pick_w    = rr_pick(MAX_CLIENTS'(req), 4'(ptr), N);
    assign pick      = pick_w[N-1:0];
    assign unused_hi = ^pick_w;

    // Index of the current one-hot owner
    always_comb begin
        gidx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) gidx = PW'(i);
        end
    end

    // Pointer moves to owner+1 so the owner ranks last next time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/dictionary_session_arbiter.sv
// Shares one dictionary between several clients, one whole session at a time.
// A session is value load, then ids, then output drain; grants rotate.
module dictionary_session_arbiter
    import dictionary_session_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS   = 4,
    parameter int DATABEAT_SIZE = 64,
    parameter int NUM_ELEMENTS  = DATABEAT_SIZE / 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_CLIENTS*DATABEAT_SIZE*8-1:0] cl_val_data,
    input  logic [NUM_CLIENTS*DATABEAT_SIZE-1:0]   cl_val_keep,
    input  logic [NUM_CLIENTS*TYPE_W-1:0]          cl_val_typ,
    input  logic [NUM_CLIENTS-1:0]                 cl_val_last,
    input  logic [NUM_CLIENTS-1:0]                 cl_val_valid,
    output logic [NUM_CLIENTS-1:0]                 cl_val_ready,
    input  logic [NUM_CLIENTS*NUM_ELEMENTS*ID_W-1:0] cl_id_data,
    input  logic [NUM_CLIENTS*NUM_ELEMENTS-1:0]    cl_id_keep,
    input  logic [NUM_CLIENTS-1:0]                 cl_id_last,
    input  logic [NUM_CLIENTS-1:0]                 cl_id_valid,
    output logic [NUM_CLIENTS-1:0]                 cl_id_ready,
    output logic [DATABEAT_SIZE*8-1:0]             cl_out_data,
    output logic [DATABEAT_SIZE-1:0]               cl_out_keep,
    output logic [TYPE_W-1:0]                      cl_out_typ,
    output logic                                   cl_out_last,
    output logic [NUM_CLIENTS-1:0]                 cl_out_valid,
    input  logic [NUM_CLIENTS-1:0]                 cl_out_ready,
    output logic [DATABEAT_SIZE*8-1:0]             dv_data,
    output logic [DATABEAT_SIZE-1:0]               dv_keep,
    output logic [TYPE_W-1:0]                      dv_typ,
    output logic                                   dv_last,
    output logic                                   dv_valid,
    input  logic                                   dv_ready,
    output logic [NUM_ELEMENTS*ID_W-1:0]           di_data,
    output logic [NUM_ELEMENTS-1:0]                di_keep,
    output logic                                   di_last,
    output logic                                   di_valid,
    input  logic                                   di_ready,
    input  logic [DATABEAT_SIZE*8-1:0]             do_data,
    input  logic [DATABEAT_SIZE-1:0]               do_keep,
    input  logic [TYPE_W-1:0]                      do_typ,
    input  logic                                   do_last,
    input  logic                                   do_valid,
    output logic                                   do_ready,
    output logic [NUM_CLIENTS-1:0]                 grant,
    output logic                                   busy,
    output logic [15:0]                            session_count
);

    localparam int DW = DATABEAT_SIZE * 8;
    localparam int KW = DATABEAT_SIZE;
    localparam int IW = NUM_ELEMENTS * ID_W;
    localparam int EW = NUM_ELEMENTS;
    localparam int GW = $clog2(NUM_CLIENTS);

    arb_state_t             state;
    logic [NUM_CLIENTS-1:0] pick;
    logic [GW-1:0]          gi;
    logic                   ids_done;
    logic                   out_done;
    logic                   in_load;
    logic                   in_ids;
    logic                   id_open;
    logic                   out_open;
    logic                   dv_hs_last;
    logic                   id_hs_last;
    logic                   out_hs_last;
    logic                   ids_fin;
    logic                   out_fin;
    logic                   finish;

    // Owner index from the one-hot grant
    always_comb begin
        gi = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant[i]) gi = GW'(i);
        end
    end

    assign in_load  = (state == LOAD);
    assign in_ids   = (state == IDS);
    assign id_open  = in_ids & ~ids_done;
    assign out_open = in_ids & ~out_done;

    assign dv_data  = cl_val_data[int'(gi)*DW +: DW];
    assign dv_keep  = cl_val_keep[int'(gi)*KW +: KW];
    assign dv_typ   = cl_val_typ[int'(gi)*TYPE_W +: TYPE_W];
    assign dv_last  = cl_val_last[gi];
    assign dv_valid = in_load & cl_val_valid[gi];

    assign di_data  = cl_id_data[int'(gi)*IW +: IW];
    assign di_keep  = cl_id_keep[int'(gi)*EW +: EW];
    assign di_last  = cl_id_last[gi];
    assign di_valid = id_open & cl_id_valid[gi];

    assign do_ready = out_open & cl_out_ready[gi];

    assign cl_out_data = do_data;
    assign cl_out_keep = do_keep;
    assign cl_out_typ  = do_typ;
    assign cl_out_last = do_last;

    // Per-client handshake returns, only the owner sees its stream
    always_comb begin
        cl_val_ready     = '0;
        cl_id_ready      = '0;
        cl_out_valid     = '0;
        cl_val_ready[gi] = in_load & dv_ready;
        cl_id_ready[gi]  = id_open & di_ready;
        cl_out_valid[gi] = out_open & do_valid;
    end

    assign dv_hs_last  = dv_valid & dv_ready & dv_last;
    assign id_hs_last  = di_valid & di_ready & di_last;
    assign out_hs_last = do_valid & do_ready & do_last;
    assign ids_fin     = ids_done | id_hs_last;
    assign out_fin     = out_done | out_hs_last;
    assign finish      = in_ids & ids_fin & out_fin;

    rr_arbiter #(
        .N(NUM_CLIENTS)
    ) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (cl_val_valid),
        .adv   (finish),
        .gnt   (grant),
        .pick  (pick)
    );

    // Session FSM with registered grant, flags and session counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant         <= '0;
            busy          <= 1'b0;
            session_count <= '0;
            ids_done      <= 1'b0;
            out_done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|cl_val_valid) begin
                        grant <= pick;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (dv_hs_last) state <= IDS;
                end
                IDS: begin
                    if (finish) begin
                        state         <= RELEASE;
                        grant         <= '0;
                        busy          <= 1'b0;
                        session_count <= session_count + 16'd1;
                        ids_done      <= 1'b0;
                        out_done      <= 1'b0;
                    end else begin
                        ids_done <= ids_fin;
                        out_done <= out_fin;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dictionary_session_arbiter.sv
// Directed bench for the dictionary session arbiter.
// Drives sessions cycle by cycle and checks grants, gating and counters.
module tb_dictionary_session_arbiter;

    localparam int N  = 4;
    localparam int DB = 64;
    localparam int NE = DB / 4;
    localparam int DW = DB * 8;
    localparam int TW = 4;
    localparam int IW = NE * 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*DW-1:0] cl_val_data;
    logic [N*DB-1:0] cl_val_keep;
    logic [N*TW-1:0] cl_val_typ;
    logic [N-1:0]    cl_val_last;
    logic [N-1:0]    cl_val_valid;
    logic [N-1:0]    cl_val_ready;
    logic [N*IW-1:0] cl_id_data;
    logic [N*NE-1:0] cl_id_keep;
    logic [N-1:0]    cl_id_last;
    logic [N-1:0]    cl_id_valid;
    logic [N-1:0]    cl_id_ready;
    logic [DW-1:0]   cl_out_data;
    logic [DB-1:0]   cl_out_keep;
    logic [TW-1:0]   cl_out_typ;
    logic            cl_out_last;
    logic [N-1:0]    cl_out_valid;
    logic [N-1:0]    cl_out_ready;
    logic [DW-1:0]   dv_data;
    logic [DB-1:0]   dv_keep;
    logic [TW-1:0]   dv_typ;
    logic            dv_last;
    logic            dv_valid;
    logic            dv_ready;
    logic [IW-1:0]   di_data;
    logic [NE-1:0]   di_keep;
    logic            di_last;
    logic            di_valid;
    logic            di_ready;
    logic [DW-1:0]   do_data;
    logic [DB-1:0]   do_keep;
    logic [TW-1:0]   do_typ;
    logic            do_last;
    logic            do_valid;
    logic            do_ready;
    logic [N-1:0]    grant;
    logic            busy;
    logic [15:0]     session_count;

    int checks   = 0;
    int failures = 0;

    dictionary_session_arbiter #(
        .NUM_CLIENTS  (N),
        .DATABEAT_SIZE(DB),
        .NUM_ELEMENTS (NE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cl_val_data  (cl_val_data),
        .cl_val_keep  (cl_val_keep),
        .cl_val_typ   (cl_val_typ),
        .cl_val_last  (cl_val_last),
        .cl_val_valid (cl_val_valid),
        .cl_val_ready (cl_val_ready),
        .cl_id_data   (cl_id_data),
        .cl_id_keep   (cl_id_keep),
        .cl_id_last   (cl_id_last),
        .cl_id_valid  (cl_id_valid),
        .cl_id_ready  (cl_id_ready),
        .cl_out_data  (cl_out_data),
        .cl_out_keep  (cl_out_keep),
        .cl_out_typ   (cl_out_typ),
        .cl_out_last  (cl_out_last),
        .cl_out_valid (cl_out_valid),
        .cl_out_ready (cl_out_ready),
        .dv_data      (dv_data),
        .dv_keep      (dv_keep),
        .dv_typ       (dv_typ),
        .dv_last      (dv_last),
        .dv_valid     (dv_valid),
        .dv_ready     (dv_ready),
        .di_data      (di_data),
        .di_keep      (di_keep),
        .di_last      (di_last),
        .di_valid     (di_valid),
        .di_ready     (di_ready),
        .do_data      (do_data),
        .do_keep      (do_keep),
        .do_typ       (do_typ),
        .do_last      (do_last),
        .do_valid     (do_valid),
        .do_ready     (do_ready),
        .grant        (grant),
        .busy         (busy),
        .session_count(session_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cl_val_data  = '0;
        cl_val_keep  = '1;
        cl_val_typ   = '0;
        cl_val_last  = '0;
        cl_val_valid = '0;
        cl_id_data   = '0;
        cl_id_keep   = '1;
        cl_id_last   = '0;
        cl_id_valid  = '0;
        cl_out_ready = '0;
        dv_ready     = 1'b1;
        di_ready     = 1'b1;
        do_data      = '0;
        do_keep      = '1;
        do_typ       = '0;
        do_last      = 1'b0;
        do_valid     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_count", 64'(session_count), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // One-beat session for client c; caller holds its value request.
    // Id last and output last handshake in the same cycle.
    task automatic session(input int c, input logic [N-1:0] exp);
        cl_val_last = '1;
        step();
        check("s_grant", 64'(grant), 64'(exp));
        check("s_vready", 64'(cl_val_ready), 64'(exp));
        step();
        cl_id_valid[c]  = 1'b1;
        cl_id_last[c]   = 1'b1;
        do_valid        = 1'b1;
        do_last         = 1'b1;
        cl_out_ready[c] = 1'b1;
        #1;
        check("s_ovalid", 64'(cl_out_valid), 64'(exp));
        check("s_divalid", 64'(di_valid), 64'h1);
        step();
        cl_id_valid  = '0;
        cl_id_last   = '0;
        do_valid     = 1'b0;
        do_last      = 1'b0;
        cl_out_ready = '0;
        #1;
        check("s_rel_grant", 64'(grant), 64'h0);
        step();
    endtask

    logic bad;

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("init_grant", 64'(grant), 64'h0);
        check("init_busy", 64'(busy), 64'h0);
        check("init_count", 64'(session_count), 64'h0);
        check("init_dvv", 64'(dv_valid), 64'h0);
        check("init_div", 64'(di_valid), 64'h0);
        check("init_dor", 64'(do_ready), 64'h0);
        check("init_vrdy", 64'(cl_val_ready), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Client 1: 2 value beats, 3 id beats, 3 output beats
        cl_val_valid[1]            = 1'b1;
        cl_val_data[1*DW +: 64]    = 64'hA1A1;
        cl_id_valid[1]             = 1'b1;
        #1;
        check("idle_grant", 64'(grant), 64'h0);
        check("idle_dvv", 64'(dv_valid), 64'h0);
        step();
        check("c1_grant", 64'(grant), 64'h2);
        check("c1_busy", 64'(busy), 64'h1);
        check("c1_dvv", 64'(dv_valid), 64'h1);
        check("c1_dvdata", dv_data[63:0], 64'hA1A1);
        check("c1_vrdy", 64'(cl_val_ready), 64'h2);
        check("c1_div0", 64'(di_valid), 64'h0);
        check("c1_idr0", 64'(cl_id_ready), 64'h0);
        step();
        cl_val_last[1]          = 1'b1;
        cl_val_data[1*DW +: 64] = 64'hB2B2;
        #1;
        check("c1_dvdata2", dv_data[63:0], 64'hB2B2);
        check("c1_div1", 64'(di_valid), 64'h0);
        step();
        cl_val_valid    = '0;
        cl_out_ready[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cl_id_last[1] = (k == 2);
            do_valid      = (k >= 1);
            do_last       = (k == 3);
            do_data[63:0] = 64'(k);
            #1;
            if (k == 0) begin
                check("c1_div", 64'(di_valid), 64'h1);
                check("c1_idr", 64'(cl_id_ready), 64'h2);
                check("c1_dvv_ids", 64'(dv_valid), 64'h0);
            end
            if (k == 3) begin
                check("c1_div_done", 64'(di_valid), 64'h0);
                check("c1_idr_done", 64'(cl_id_ready), 64'h0);
                check("c1_ovalid", 64'(cl_out_valid), 64'h2);
                check("c1_odata", cl_out_data[63:0], 64'h3);
                check("c1_dor", 64'(do_ready), 64'h1);
            end
            step();
        end
        check("c1_rel_grant", 64'(grant), 64'h0);
        check("c1_rel_busy", 64'(busy), 64'h0);
        check("c1_rel_dor", 64'(do_ready), 64'h0);
        check("c1_count", 64'(session_count), 64'h1);
        cl_id_valid  = '0;
        cl_id_last   = '0;
        do_valid     = 1'b0;
        do_last      = 1'b0;
        cl_out_ready = '0;
        step();
        check("c1_idle_busy", 64'(busy), 64'h0);

        // Pointer is at 2: clients 0 and 3 request, 3 wins
        cl_val_valid = 4'b1001;
        session(3, 4'b1000);
        cl_val_valid[3] = 1'b0;
        session(0, 4'b0001);
        cl_val_valid = '0;
        check("ptr_count", 64'(session_count), 64'h3);

        // Clients 0 and 2 requesting continuously from reset
        do_reset();
        cl_val_valid = 4'b0101;
        session(0, 4'b0001);
        session(2, 4'b0100);
        session(0, 4'b0001);
        cl_val_valid = '0;
        check("alt_count", 64'(session_count), 64'h3);

        // Client 1, typed load, ids finish first, output backpressure
        cl_val_valid[1]         = 1'b1;
        cl_val_last             = '1;
        cl_val_typ[1*TW +: TW]  = 4'h6;
        step();
        check("t_grant", 64'(grant), 64'h2);
        check("t_dvtyp", 64'(dv_typ), 64'h6);
        step();
        cl_val_valid    = '0;
        cl_id_valid[1]  = 1'b1;
        cl_id_last[1]   = 1'b1;
        do_valid        = 1'b1;
        do_last         = 1'b0;
        cl_out_ready[1] = 1'b1;
        step();
        do_last         = 1'b1;
        do_typ          = 4'h6;
        cl_out_ready[1] = 1'b0;
        bad             = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (do_ready !== 1'b0 || cl_out_valid !== 4'b0010 ||
                di_valid !== 1'b0 || grant !== 4'b0010)
                bad = 1'b1;
            step();
        end
        check("bp_hold", 64'(bad), 64'h0);
        cl_out_ready[1] = 1'b1;
        #1;
        check("bp_dor", 64'(do_ready), 64'h1);
        check("bp_typ", 64'(cl_out_typ), 64'h6);
        check("bp_last", 64'(cl_out_last), 64'h1);
        step();
        check("bp_rel_grant", 64'(grant), 64'h0);
        check("bp_count", 64'(session_count), 64'h4);
        clear_inputs();
        step();

        // Client 3 stalls its ids while client 0 waits
        do_reset();
        cl_val_valid = 4'b1000;
        cl_val_last  = '1;
        step();
        check("st_grant", 64'(grant), 64'h8);
        step();
        cl_val_valid = 4'b0001;
        bad          = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (grant !== 4'b1000) bad = 1'b1;
            step();
        end
        check("st_hold", 64'(bad), 64'h0);
        check("st_grant2", 64'(grant), 64'h8);
        cl_id_valid[3]  = 1'b1;
        cl_id_last[3]   = 1'b1;
        do_valid        = 1'b1;
        do_last         = 1'b1;
        cl_out_ready[3] = 1'b1;
        step();
        cl_id_valid  = '0;
        cl_id_last   = '0;
        do_valid     = 1'b0;
        cl_out_ready = '0;
        step();
        step();
        check("st_next", 64'(grant), 64'h1);
        step();

        // Reset while client 0 is in its id phase
        cl_id_valid[0]  = 1'b1;
        do_valid        = 1'b1;
        cl_out_ready[0] = 1'b1;
        #1;
        check("r_pre_div", 64'(di_valid), 64'h1);
        rst_n = 1'b0;
        #1;
        check("r_grant", 64'(grant), 64'h0);
        check("r_busy", 64'(busy), 64'h0);
        check("r_div", 64'(di_valid), 64'h0);
        check("r_idr", 64'(cl_id_ready), 64'h0);
        check("r_ovalid", 64'(cl_out_valid), 64'h0);
        check("r_dor", 64'(do_ready), 64'h0);
        clear_inputs();
        cl_val_valid = 4'b0011;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("r_first", 64'(grant), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dictionary_session_arbiter.md
Name: dictionary_session_arbiter

Overview:
- Shares one TypedDictionary instance between NUM_CLIENTS independent requesters.
- A session is one client's complete value load, then its full id stream, then the drain of every output beat.
- Sessions are granted round-robin and never interleave, so dictionary contents always belong to the granted client.
- Sits between the query-operator clients and the dictionary.

Parameters:
- NUM_CLIENTS, 4, number of requesters (2..16)
- DATABEAT_SIZE, 64, bytes per value/output beat
- NUM_ELEMENTS, DATABEAT_SIZE/4, id lanes per id beat
- id_t, logic[15:0], id element type; ID_W = $bits(id_t)
- TYPE_W, $bits(libstf::type_t), width of the type tag

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cl_val_data  in  NUM_CLIENTS*DATABEAT_SIZE*8  per-client value beats
- cl_val_keep  in  NUM_CLIENTS*DATABEAT_SIZE  per-client byte keep
- cl_val_typ  in  NUM_CLIENTS*TYPE_W  per-client type tag
- cl_val_last / cl_val_valid  in  NUM_CLIENTS  per-client value stream control
- cl_val_ready  out  NUM_CLIENTS  per-client value ready
- cl_id_data  in  NUM_CLIENTS*NUM_ELEMENTS*ID_W  per-client id beats
- cl_id_keep  in  NUM_CLIENTS*NUM_ELEMENTS  per-client id keep
- cl_id_last / cl_id_valid  in  NUM_CLIENTS  per-client id stream control
- cl_id_ready  out  NUM_CLIENTS  per-client id ready
- cl_out_data  out  DATABEAT_SIZE*8  broadcast output data
- cl_out_keep  out  DATABEAT_SIZE  broadcast output keep
- cl_out_typ  out  TYPE_W  broadcast output type
- cl_out_last  out  1  broadcast output last
- cl_out_valid  out  NUM_CLIENTS  output valid, granted client only
- cl_out_ready  in  NUM_CLIENTS  per-client output ready
- dv_data / dv_keep / dv_typ / dv_last / dv_valid  out  matching widths  values stream to the dictionary
- dv_ready  in  1
- di_data / di_keep / di_last / di_valid  out  matching widths  id stream to the dictionary
- di_ready  in  1
- do_data / do_keep / do_typ / do_last / do_valid  in  matching widths  dictionary output
- do_ready  out  1
- grant  out  NUM_CLIENTS  one-hot owner, 0 when idle
- busy  out  1  session in progress
- session_count  out  16  completed sessions, wraps at 2^16

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; grant, busy and session_count are 0.
  - RR pointer is 0; ids_done and out_done are 0.
  - All valid and ready outputs are 0.
- Request: req[i] = cl_val_valid[i]. Id or output activity without value valid never requests.
- IDLE:
  - If any req, register the first requester at or after the RR pointer, modulo NUM_CLIENTS.
  - grant and busy rise next cycle; state goes to LOAD.
  - Arbitration latency is 1 cycle. No stream signal passes through in IDLE.
- LOAD:
  - dv_* = granted client's value signals. cl_val_ready[g] = dv_ready; all other readies are 0.
  - di_valid = 0 and cl_id_ready = 0: ids are held back until the load completes.
  - Handshake with dv_last=1 moves to IDS the next cycle.
- IDS:
  - di_* = granted client's id signals. cl_id_ready[g] = di_ready.
  - do_ready = cl_out_ready[g]. cl_out_valid[g] = do_valid; all others are 0.
  - Id handshake with di_last sets ids_done. Output handshake with do_last sets out_done.
  - When both flags are set (either order, or same cycle), go to RELEASE.
  - After ids_done, di_valid = 0 and the client's id ready is 0.
- Output broadcast: do_data, do_keep, do_typ and do_last drive cl_out_* directly in every state.
- RELEASE (1 cycle):
  - grant = 0, busy = 0, do_ready = 0.
  - RR pointer = g+1 (wrapping to 0 after NUM_CLIENTS-1); session_count += 1; flags clear.
  - Then IDLE.
  - Gives a guaranteed 1-cycle gap, so the dictionary sees no back-to-back values handshake from a new owner in the same cycle.
- Output handling outside IDS: do_ready = 0 in IDLE, LOAD and RELEASE. A do_valid seen there is held back, not dropped.
- Stalls: if the granted client drops valid mid-session, the grant is held indefinitely; no timeout.
- Fairness: a client that re-requests immediately waits behind every other pending requester.
- Combinational paths: all dictionary-side and client-side forwarding is combinational mux/gating. Only the FSM, grant, pointer, flags and counter are registered.

Decomposition:
- Extend the dictionary package with:
  - enum arb_state_t {IDLE, LOAD, IDS, RELEASE}
  - function rr_pick(req, ptr) returning a one-hot grant
- Sub-module rr_arbiter (parameter N): combinational round-robin pick plus a registered pointer. Reusable by other shared operators.

Test Plan:
- Single client 1, 2 value beats, 3 id beats, 3 output beats:
  - grant = 0010 one cycle after the first valid.
  - No di_valid before the 2nd dv handshake.
  - session_count = 1; RELEASE is 1 cycle.
- Clients 0 and 2 requesting continuously from reset, each with 1 value beat, 1 id beat and 1 output beat:
  - grants alternate 0001, 0100, 0001.
  - cl_val_ready to the non-granted client is always 0.
- 64-bit type session with 1 id beat and 2 output beats:
  - ids_done is set first, and the grant holds until the second do_last handshake.
  - Variant: do_last and di_last handshake in the same cycle still completes the session.
- Backpressure:
  - cl_out_ready[g] = 0 for 10 cycles gives do_ready = 0 for those cycles, with no lost beats.
  - Randomised ready, 100 sessions: output beat count equals dictionary beat count.
- Client 3 drops cl_id_valid for 50 cycles mid-stream: grant stays 1000 and client 0's request waits.
- rst_n asserted in IDS: grant = 0, busy = 0 and all readies and valids 0 immediately. After release, the first request gets client 0.
